mdu_unit: RTL

Iterative multiply/divide unit for the pipelined MIPS CPU, executing MULT, MULTU, DIV and DIVU and holding the architectural HI/LO registers. It sits in the EX stage beside the ALU, consuming the same `rs`/`rt` operands read from the register file. The HI/LO results feed the MFHI/MFLO write-back path into the register file write port. While an operation is in flight, `busy_o` stalls the issue of any later MDU or MFHI/MFLO instruction.

---
 rtl/mdu_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Iterative MIPS multiply/divide unit: owns HI/LO and steps one shift-add or
// restoring shift-subtract per cycle, fixed WIDTH-cycle latency.
module mdu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // opnd is the multiplicand (multiply) or the divisor magnitude (divide)
    typedef struct packed {
        logic             is_div;
        logic             neg_q;
        logic             neg_r;
        logic             div0;
        logic [WIDTH-1:0] opnd;
    } op_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    op_t                op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic             in_div, in_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign in_div    = op_i[1];
    assign in_signed = ~op_i[0];
    assign rs_neg    = in_signed & rs_data_i[WIDTH-1];
    assign rt_neg    = in_signed & rt_data_i[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag    = rt_neg ? -rt_data_i : rt_data_i;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, prod;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_q.opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_q.opnd};
        // borrow out means the trial subtract failed: restore and shift in 0
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        step = op_q.is_div ? div_next : mul_next;
        prod = op_q.neg_q ? -step : step;
        quo  = step[WIDTH-1:0];
        rem  = step[2*WIDTH-1:WIDTH];
        if (op_q.is_div) begin
            // divide by zero leaves rem = |rs|, so the sign fixup restores rs
            fin_lo = op_q.div0 ? '1 : (op_q.neg_q ? -quo : quo);
            fin_hi = op_q.neg_r ? -rem : rem;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (cancel_i) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= step;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            hi_q   <= fin_hi;
                            lo_q   <= fin_lo;
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start_i && !cancel_i) begin
                        op_q <= '{is_div: in_div,
                                  neg_q:  rs_neg ^ rt_neg,
                                  neg_r:  rs_neg,
                                  div0:   in_div && (rt_data_i == '0),
                                  opnd:   in_div ? rt_mag : rs_mag};
                        acc    <= {{WIDTH{1'b0}}, (in_div ? rs_mag : rt_mag)};
                        cnt    <= '0;
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                    end else begin
                        if (hi_we_i) hi_q <= rs_data_i;
                        if (lo_we_i) lo_q <= rs_data_i;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
